mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares one external memory bus (MREQ/WRITE/SIZE/address/data, active-low ACK_n) between
//   the instruction-fetch port and the load/store port of the core. Buffers one pulsed
//   request per port, arbitrates, runs a single bus transaction at a time, waits for ACK_n,
//   and returns data with a one-cycle ready pulse. A watchdog aborts transactions that get no ACK.
// PARAMETERS
//   BIT_WIDTH    32  address/data width
//   TIMEOUT_CYC  64  busy cycles without ACK before abort; 0 disables watchdog
//   CNT_W        8   watchdog counter width (must hold TIMEOUT_CYC)
// PORTS
//   clk       in   1          clock, all state on rising edge
//   rst       in   1          asynchronous active-low reset
//   if_req    in   1          fetch request pulse (1 cycle)
//   if_addr   in   BIT_WIDTH  fetch address, sampled with if_req
//   if_ready  out  1          fetch done pulse; if_rdata valid this cycle
//   if_rdata  out  BIT_WIDTH  fetched instruction word
//   dm_req    in   1          data request pulse (1 cycle)
//   dm_write  in   1          1=store 0=load, sampled with dm_req
//   dm_size   in   2          00 word, 01 half, 10 byte, sampled with dm_req
//   dm_addr   in   BIT_WIDTH  data address, sampled with dm_req
//   dm_wdata  in   BIT_WIDTH  store data (low-aligned), sampled with dm_req
//   dm_ready  out  1          data done pulse; dm_rdata valid this cycle on loads
//   dm_rdata  out  BIT_WIDTH  load data as returned by the bus (low-aligned, zero-extended)
//   err       out  1          1 with if_ready/dm_ready when that transaction timed out
//   busy      out  1          bus transaction in flight
//   MAD       out  BIT_WIDTH  bus address
//   MREQ      out  1          bus request, held high for the whole transaction
//   WRITE     out  1          bus direction
//   SIZE      out  2          bus access size (fetch always 00)
//   MDT_o     out  BIT_WIDTH  bus write data
//   MDT_oe    out  1          write-data drive enable (= MREQ & WRITE)
//   MDT_i     in   BIT_WIDTH  bus read data, sampled when ACK_n sampled low
//   ACK_n     in   1          bus acknowledge, active low
// BEHAVIOUR
//   - Reset: all outputs 0 (MREQ, WRITE, MDT_oe, ready pulses, err, busy, MAD, SIZE, data);
//     pending flags cleared, state IDLE, last_grant=IF. Reset mid-transaction drops it silently.
//   - Pending: req pulse sets that port's pending flag + captures its fields. Req on a port whose
//     flag is set or whose transaction is on the bus is ignored (fields not overwritten).
//   - FSM IDLE/IBUS/DBUS. IDLE: only IF pending -> IBUS; only DM pending -> DBUS; both ->
//     grant opposite of last_grant (first contest goes to DM). Grant clears pending flag,
//     updates last_grant, loads bus registers. A req arriving in IDLE is eligible next cycle.
//   - Bus outputs registered: MREQ/MAD/WRITE/SIZE/MDT_o valid from cycle after grant decision,
//     stable until ACK_n sampled low or timeout.
//   - ACK_n ignored unless in IBUS/DBUS. On rising edge with ACK_n=0: MDT_i captured into
//     if_rdata/dm_rdata, matching ready=1 for exactly one cycle, MREQ/WRITE/MDT_oe drop, -> IDLE.
//     dm_rdata unchanged on stores. rdata regs hold value until next completion.
//   - Min latency: req at edge k, grant at k+1, MREQ high after k+1, ACK at k+2 -> ready high
//     after k+2. Back-to-back: IDLE re-arbitrates the cycle ready is high.
//   - Watchdog: counter clears on grant, increments each bus cycle with ACK_n=1; when it reaches
//     TIMEOUT_CYC: abort (MREQ=0), ready=1 with err=1, rdata=0, -> IDLE. err=0 otherwise.
//   - busy = (state != IDLE). Never more than one port ready in the same cycle.
// TESTING
//   1 Fetch only: if_req addr=0x0000_0010, ACK_n low 1 cycle after MREQ -> MAD=0x10, SIZE=00,
//     WRITE=0, if_ready pulse 1 cycle with if_rdata=MDT_i=0x0050_0093, err=0.
//   2 Same-cycle if_req+dm_req(load, 0x0800_0004) -> DM served first, then IF; repeat both ->
//     IF first (alternation); no ready overlap.
//   3 Store byte dm_size=10 addr=0xf000_0000 wdata=0x41 -> MREQ=WRITE=MDT_oe=1, SIZE=10,
//     MDT_o=0x41 held 3 cycles until ACK_n=0; dm_ready pulse, dm_rdata unchanged.
//   4 TIMEOUT_CYC=4, ACK_n held 1 -> MREQ drops after 4 busy cycles, dm_ready=err=1, rdata=0;
//     next queued fetch then proceeds normally.
//   5 Second if_req while fetch outstanding -> ignored, one if_ready only, original address kept.
//   6 rst low mid-transaction -> all outputs 0 at once; after release no stale ready/MREQ.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one external memory bus, one transaction at a time.
// Grant one cycle after a request, ready one cycle after ACK_n low; requests on a busy port are dropped.
module mem_bus_arbiter #(
  parameter int BIT_WIDTH   = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [BIT_WIDTH-1:0] if_addr,
  output logic                 if_ready,
  output logic [BIT_WIDTH-1:0] if_rdata,
  input  logic                 dm_req,
  input  logic                 dm_write,
  input  logic [1:0]           dm_size,
  input  logic [BIT_WIDTH-1:0] dm_addr,
  input  logic [BIT_WIDTH-1:0] dm_wdata,
  output logic                 dm_ready,
  output logic [BIT_WIDTH-1:0] dm_rdata,
  output logic                 err,
  output logic                 busy,
  output logic [BIT_WIDTH-1:0] MAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  output logic [BIT_WIDTH-1:0] MDT_o,
  output logic                 MDT_oe,
  input  logic [BIT_WIDTH-1:0] MDT_i,
  input  logic                 ACK_n
);

  typedef enum logic [1:0] {S_IDLE, S_IBUS, S_DBUS} state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t               state_q, state_d;
  logic                 if_pend_q, dm_pend_q, last_dm_q;
  logic [BIT_WIDTH-1:0] if_addr_q, dm_addr_q, dm_wdata_q;
  logic                 dm_write_q;
  logic [1:0]           dm_size_q;
  logic [CNT_W-1:0]     wd_q;
  logic                 mreq_q, write_q;
  logic [1:0]           size_q;
  logic [BIT_WIDTH-1:0] mad_q, mdt_o_q, if_rdata_q, dm_rdata_q;
  logic                 if_ready_q, dm_ready_q, err_q;
  logic                 grant_if, grant_dm, done, tmo;

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // On a contest, the port that did not win last time gets the bus.
        if (if_pend_q && (!dm_pend_q || last_dm_q)) begin
          grant_if = 1'b1;
          state_d  = S_IBUS;
        end else if (dm_pend_q) begin
          grant_dm = 1'b1;
          state_d  = S_DBUS;
        end
      end
      S_IBUS, S_DBUS: begin
        if (!ACK_n) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if ((TIMEOUT_CYC != 0) && (wd_q == WD_LAST)) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      if_pend_q  <= 1'b0;
      dm_pend_q  <= 1'b0;
      last_dm_q  <= 1'b0;
      if_addr_q  <= '0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_write_q <= 1'b0;
      dm_size_q  <= 2'b00;
      wd_q       <= '0;
      mreq_q     <= 1'b0;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      mad_q      <= '0;
      mdt_o_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      err_q      <= 1'b0;

      if (grant_if) begin
        if_pend_q <= 1'b0;
      end else if (if_req && !if_pend_q && state_q != S_IBUS) begin
        if_pend_q <= 1'b1;
        if_addr_q <= if_addr;
      end

      if (grant_dm) begin
        dm_pend_q <= 1'b0;
      end else if (dm_req && !dm_pend_q && state_q != S_DBUS) begin
        dm_pend_q  <= 1'b1;
        dm_write_q <= dm_write;
        dm_size_q  <= dm_size;
        dm_addr_q  <= dm_addr;
        dm_wdata_q <= dm_wdata;
      end

      if (grant_if) begin
        last_dm_q <= 1'b0;
        mreq_q    <= 1'b1;
        write_q   <= 1'b0;
        size_q    <= 2'b00;
        mad_q     <= if_addr_q;
        mdt_o_q   <= '0;
        wd_q      <= '0;
      end else if (grant_dm) begin
        last_dm_q <= 1'b1;
        mreq_q    <= 1'b1;
        write_q   <= dm_write_q;
        size_q    <= dm_size_q;
        mad_q     <= dm_addr_q;
        mdt_o_q   <= dm_wdata_q;
        wd_q      <= '0;
      end else if (state_q != S_IDLE && ACK_n && !tmo) begin
        wd_q <= wd_q + CNT_W'(1);
      end

      if (done || tmo) begin
        mreq_q  <= 1'b0;
        write_q <= 1'b0;
        err_q   <= tmo;
        if (state_q == S_IBUS) begin
          if_ready_q <= 1'b1;
          if_rdata_q <= tmo ? '0 : MDT_i;
        end else begin
          dm_ready_q <= 1'b1;
          // A completed store leaves the last load result in place.
          if (tmo)           dm_rdata_q <= '0;
          else if (!write_q) dm_rdata_q <= MDT_i;
        end
      end
    end
  end

  assign if_ready = if_ready_q;
  assign if_rdata = if_rdata_q;
  assign dm_ready = dm_ready_q;
  assign dm_rdata = dm_rdata_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);
  assign MAD      = mad_q;
  assign MREQ     = mreq_q;
  assign WRITE    = write_q;
  assign SIZE     = size_q;
  assign MDT_o    = mdt_o_q;
  assign MDT_oe   = mreq_q & write_q;

endmodule
